exu_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational execute-operand selector.
- Selects ALU operands A/B from rs1/rs2/pc/imm using the ers1/ers2/specinst controls, with optional bypass from N writeback channels.
- Computes the ALU result, including RV64 word ops. Sits between decode and the LSU/writeback.
- Two register stages, with a valid/ready handshake on both sides.

---
 rtl/exu_pkg.sv | 38 +++
 rtl/exu_alu.sv | 77 +++++++
 rtl/exu_pipe.sv | 148 ++++++++++++++
 tb/tb_exu_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// ============================================================================
// Module   : exu_pkg
// Brief    : Shared encodings for the execute pipe (special-inst and ALU ops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exu_pkg;

    localparam int SPEC_W  = 3;
    localparam int ALUOP_W = 4;

    typedef enum logic [SPEC_W-1:0] {
        SPEC_NONE  = 3'd0,
        SPEC_JAL   = 3'd1,
        SPEC_JALR  = 3'd2,
        SPEC_AUIPC = 3'd3,
        SPEC_LUI   = 3'd4,
        SPEC_STORE = 3'd5
    } spec_e;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } aluop_e;

endpackage

`default_nettype wire

// File: rtl/exu_alu.sv
// ============================================================================
// Module   : exu_alu
// Brief    : Combinational ALU with RV64 word variants for ADD/SUB/shifts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exu_alu
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic                  word_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [5:0]            w_shamt;
    logic [4:0]            w_shamt_w;
    logic [31:0]           w_a32;
    logic [31:0]           w_b32;
    logic [31:0]           w_res32;
    logic [DATA_WIDTH-1:0] w_res_full;
    logic                  w_use_word;

    always_comb begin
        w_shamt    = b_i[5:0];
        w_shamt_w  = b_i[4:0];
        w_a32      = a_i[31:0];
        w_b32      = b_i[31:0];
        w_res_full = '0;
        w_res32    = '0;
        w_use_word = 1'b0;
        case (aluop_i)
            ALU_ADD: begin
                w_res_full = a_i + b_i;
                w_res32    = w_a32 + w_b32;
                w_use_word = word_i;
            end
            ALU_SUB: begin
                w_res_full = a_i - b_i;
                w_res32    = w_a32 - w_b32;
                w_use_word = word_i;
            end
            ALU_SLL: begin
                w_res_full = a_i << w_shamt;
                w_res32    = w_a32 << w_shamt_w;
                w_use_word = word_i;
            end
            ALU_SLT:   w_res_full = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  w_res_full = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:   w_res_full = a_i ^ b_i;
            ALU_SRL: begin
                w_res_full = a_i >> w_shamt;
                w_res32    = w_a32 >> w_shamt_w;
                w_use_word = word_i;
            end
            ALU_SRA: begin
                w_res_full = $unsigned($signed(a_i) >>> w_shamt);
                w_res32    = $unsigned($signed(w_a32) >>> w_shamt_w);
                w_use_word = word_i;
            end
            ALU_OR:    w_res_full = a_i | b_i;
            ALU_AND:   w_res_full = a_i & b_i;
            ALU_PASSB: w_res_full = b_i;
            default:   w_res_full = '0;
        endcase
    end

    // Word results are sign-extended from bit 31 by the signed size cast.
    assign result_o = w_use_word ? DATA_WIDTH'($signed(w_res32)) : w_res_full;

endmodule

`default_nettype wire

// File: rtl/exu_pipe.sv
// ============================================================================
// Module   : exu_pipe
// Brief    : Two-stage execute pipe: operand select/bypass (S1), ALU (S2),
//            valid/ready handshake on both sides.
// Options  : EXU_BYPASS_EN - enables forwarding from the byp_* channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exu_pipe
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_BYPASS = 2,
    parameter int REG_IDX_W  = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic                             ers1_i,
    input  logic                             ers2_i,
    input  logic [SPEC_W-1:0]                specinst_i,
    input  logic [ALUOP_W-1:0]               aluop_i,
    input  logic                             word_i,
    input  logic [REG_IDX_W-1:0]             rs1_idx_i,
    input  logic [REG_IDX_W-1:0]             rs2_idx_i,
    input  logic [DATA_WIDTH-1:0]            rs1_i,
    input  logic [DATA_WIDTH-1:0]            rs2_i,
    input  logic [DATA_WIDTH-1:0]            pc_i,
    input  logic [DATA_WIDTH-1:0]            imme_i,
    input  logic [NUM_BYPASS-1:0]            byp_valid_i,
    input  logic [NUM_BYPASS*REG_IDX_W-1:0]  byp_rd_i,
    input  logic [NUM_BYPASS*DATA_WIDTH-1:0] byp_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            result_o,
    output logic [DATA_WIDTH-1:0]            store_data_o
);

    logic [DATA_WIDTH-1:0] w_rs1_eff, w_rs2_eff;
    logic [DATA_WIDTH-1:0] a_d, b_d, st_d, w_alu_res;
    logic                  w_s2_adv, w_s1_adv, w_accept;

    logic                  s1_valid_q, s2_valid_q;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q, s1_st_q;
    logic [ALUOP_W-1:0]    s1_op_q;
    logic                  s1_word_q;
    logic [DATA_WIDTH-1:0] result_q, store_q;

`ifdef EXU_BYPASS_EN
    // Walk channels high to low so the lowest-numbered match wins.
    always_comb begin
        w_rs1_eff = rs1_i;
        w_rs2_eff = rs2_i;
        for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
            if (byp_valid_i[k] && (byp_rd_i[k*REG_IDX_W +: REG_IDX_W] == rs1_idx_i) &&
                (rs1_idx_i != '0))
                w_rs1_eff = byp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (byp_valid_i[k] && (byp_rd_i[k*REG_IDX_W +: REG_IDX_W] == rs2_idx_i) &&
                (rs2_idx_i != '0))
                w_rs2_eff = byp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_valid_i, byp_rd_i, byp_data_i, rs1_idx_i, rs2_idx_i};
    assign w_rs1_eff    = rs1_i;
    assign w_rs2_eff    = rs2_i;
`endif

    always_comb begin
        if (ers1_i)
            a_d = w_rs1_eff;
        else if (specinst_i == SPEC_JAL || specinst_i == SPEC_JALR || specinst_i == SPEC_AUIPC)
            a_d = pc_i;
        else
            a_d = '0;

        if (ers2_i)
            b_d = (specinst_i == SPEC_STORE) ? imme_i : w_rs2_eff;
        else if (specinst_i == SPEC_LUI)
            b_d = imme_i;
        else if (specinst_i == SPEC_JAL || specinst_i == SPEC_JALR)
            b_d = DATA_WIDTH'(4);
        else
            b_d = imme_i;

        st_d = (specinst_i == SPEC_STORE) ? w_rs2_eff : '0;
    end

    assign w_s2_adv   = !s2_valid_q || out_ready_i;
    assign w_s1_adv   = s1_valid_q && w_s2_adv;
    assign in_ready_o = !s1_valid_q || w_s2_adv;
    assign w_accept   = in_valid_i && in_ready_o;

    exu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .aluop_i  (s1_op_q),
        .word_i   (s1_word_q),
        .result_o (w_alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_st_q    <= '0;
            s1_op_q    <= '0;
            s1_word_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
        end else begin
            if (w_accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= a_d;
                s1_b_q     <= b_d;
                s1_st_q    <= st_d;
                s1_op_q    <= aluop_i;
                s1_word_q  <= word_i;
            end else if (w_s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            // Output registers only load on a real S1->S2 transfer, so they
            // hold the last result while stalled or idle.
            if (w_s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= w_alu_res;
                    store_q  <= s1_st_q;
                end
            end
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign result_o     = result_q;
    assign store_data_o = store_q;

endmodule

`default_nettype wire

// File: tb/tb_exu_pipe.sv
// ============================================================================
// Module   : tb_exu_pipe
// Brief    : Self-checking bench for exu_pipe against a behavioural model.
// Options  : EXU_BYPASS_EN - model forwards from the byp_* channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exu_pipe;

    localparam int DW = 64;
    localparam int NB = 2;
    localparam int RW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i, in_ready_o, ers1_i, ers2_i, word_i;
    logic [2:0]       specinst_i;
    logic [3:0]       aluop_i;
    logic [RW-1:0]    rs1_idx_i, rs2_idx_i;
    logic [DW-1:0]    rs1_i, rs2_i, pc_i, imme_i;
    logic [NB-1:0]    byp_valid_i;
    logic [NB*RW-1:0] byp_rd_i;
    logic [NB*DW-1:0] byp_data_i;
    logic             out_valid_o, out_ready_i;
    logic [DW-1:0]    result_o, store_data_o;

    always #5 clk = ~clk;

    exu_pipe #(.DATA_WIDTH(DW), .NUM_BYPASS(NB), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ers1_i(ers1_i), .ers2_i(ers2_i), .specinst_i(specinst_i), .aluop_i(aluop_i),
        .word_i(word_i), .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imme_i(imme_i),
        .byp_valid_i(byp_valid_i), .byp_rd_i(byp_rd_i), .byp_data_i(byp_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .store_data_o(store_data_o)
    );

    typedef struct {
        logic [63:0] res;
        logic [63:0] st;
        int          age;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   last_acc;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [63:0] eff(input logic [4:0] idx, input logic [63:0] rf);
        logic [63:0] v;
        bit          found;
        v     = rf;
        found = 0;
        for (int k = 0; k < NB; k++)
            if (!found && byp_valid_i[k] && byp_rd_i[k*RW +: RW] == idx && idx != 5'd0) begin
                v     = byp_data_i[k*DW +: DW];
                found = 1;
            end
`ifdef EXU_BYPASS_EN
        return v;
`else
        return (v == v) ? rf : rf;
`endif
    endfunction

    function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op, input logic word);
        logic [31:0] lo;
        longint      sa;
        int          sh;
        sa = a;
        sh = word ? int'(b[4:0]) : int'(b[5:0]);
        if (word && (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7)) begin
            case (op)
                4'd0:    lo = a[31:0] + b[31:0];
                4'd1:    lo = a[31:0] - b[31:0];
                4'd2:    lo = a[31:0] << sh;
                4'd6:    lo = a[31:0] >> sh;
                default: lo = 32'(int'(a[31:0]) >>> sh);
            endcase
            return {{32{lo[31]}}, lo};
        end
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            4'd4:    return (a < b) ? 64'd1 : 64'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return 64'(sa >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic exp_t model_op();
        exp_t        e;
        logic [63:0] r1, r2, a, b;
        r1 = eff(rs1_idx_i, rs1_i);
        r2 = eff(rs2_idx_i, rs2_i);
        if (ers1_i) a = r1;
        else if (specinst_i inside {3'd1, 3'd2, 3'd3}) a = pc_i;
        else a = 64'd0;
        if (ers2_i) b = (specinst_i == 3'd5) ? imme_i : r2;
        else if (specinst_i == 3'd4) b = imme_i;
        else if (specinst_i inside {3'd1, 3'd2}) b = 64'd4;
        else b = imme_i;
        e.st  = (specinst_i == 3'd5) ? r2 : 64'd0;
        e.res = ref_alu(a, b, aluop_i, word_i);
        e.age = 1;
        return e;
    endfunction

    // One clock: check outputs against the model, advance the model, return at negedge.
    task automatic cycle();
        bit   acc, drn, ev, rdy;
        exp_t e;
        #1;
        acc = 0;
        drn = 0;
        e   = model_op();
        if (!rst) begin
            ev  = (q.size() > 0) && (q[0].age >= 2);
            rdy = (q.size() < 2) || out_ready_i;
            check1("in_ready", in_ready_o, rdy);
            check1("out_valid", out_valid_o, ev);
            if (ev) begin
                check64("result", result_o, q[0].res);
                check64("store_data", store_data_o, q[0].st);
            end
            acc = in_valid_i && rdy;
            drn = ev && out_ready_i;
        end
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (acc) q.push_back(e);
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic send();
        int n = 0;
        in_valid_i = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        check1("send_accepted", last_acc, 1'b1);
        in_valid_i = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] sp, input logic [3:0] op, input logic wd,
                          input logic e1, input logic e2, input logic [4:0] i1,
                          input logic [4:0] i2, input logic [63:0] v1, input logic [63:0] v2,
                          input logic [63:0] pc, input logic [63:0] imm);
        specinst_i = sp;  aluop_i = op;  word_i = wd;  ers1_i = e1;  ers2_i = e2;
        rs1_idx_i = i1;   rs2_idx_i = i2;  rs1_i = v1;  rs2_i = v2;  pc_i = pc;
        imme_i = imm;     byp_valid_i = '0;  byp_rd_i = '0;  byp_data_i = '0;
    endtask

    task automatic rand_op();
        specinst_i  = 3'($urandom_range(0, 7));
        aluop_i     = 4'($urandom_range(0, 15));
        word_i      = 1'($urandom_range(0, 1));
        ers1_i      = 1'($urandom_range(0, 1));
        ers2_i      = 1'($urandom_range(0, 1));
        rs1_idx_i   = 5'($urandom_range(0, 3));
        rs2_idx_i   = 5'($urandom_range(0, 3));
        rs1_i       = {$urandom, $urandom};
        rs2_i       = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
        pc_i        = {$urandom, $urandom};
        imme_i      = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
        byp_valid_i = 2'($urandom_range(0, 3));
        byp_rd_i    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        byp_data_i  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic expect_out(input string tag, input logic [63:0] res, input logic [63:0] st);
        #1;
        check1({tag, "_valid"}, out_valid_o, 1'b1);
        check64({tag, "_result"}, result_o, res);
        check64({tag, "_store"}, store_data_o, st);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  in_valid_i = 1'b0;  out_ready_i = 1'b1;
        set_op(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check1("rst_out_valid", out_valid_o, 1'b0);
        check1("rst_in_ready", in_ready_o, 1'b1);
        check64("rst_result", result_o, 64'd0);
        check64("rst_store", store_data_o, 64'd0);
        cycle();

        // ADD: accept in cycle 0, result visible in cycle 2.
        set_op(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 64'd0);
        send();
        cycle();
        expect_out("add", 64'd12, 64'd0);

        set_op(3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h8000_0000, 64'd0);
        send();  cycle();
        expect_out("jal", 64'h8000_0004, 64'd0);

        set_op(3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h44, 64'h1234_5000);
        send();  cycle();
        expect_out("lui", 64'h1234_5000, 64'd0);

        set_op(3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 64'h7FFF_FFFF, 64'd1, 64'd0, 64'd0);
        send();  cycle();
        expect_out("addw", 64'hFFFF_FFFF_8000_0000, 64'd0);

        set_op(3'd5, 4'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd3, 64'h100, 64'h55, 64'd0, 64'd8);
        byp_valid_i = 2'b11;
        byp_rd_i    = {5'd3, 5'd3};
        byp_data_i  = {64'hCD, 64'hAB};
        send();  cycle();
`ifdef EXU_BYPASS_EN
        expect_out("store", 64'h108, 64'hAB);
`else
        expect_out("store", 64'h108, 64'h55);
`endif

        // Backpressure: three ADDs with the sink stalled for four cycles.
        out_ready_i = 1'b0;
        set_op(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd1, 64'd0, 64'd0);
        send();
        set_op(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd2, 64'd0, 64'd0);
        send();
        set_op(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd3, 64'd0, 64'd0);
        in_valid_i = 1'b1;
        #1;
        check1("bp_in_ready_low", in_ready_o, 1'b0);
        check64("bp_hold_first", result_o, 64'd2);
        cycle();
        cycle();
        check64("bp_hold_after", result_o, 64'd2);
        out_ready_i = 1'b1;
        send();
        repeat (5) cycle();
        check64("bp_drained", 64'(q.size()), 64'd0);

        // Reset with both stages occupied.
        out_ready_i = 1'b0;
        rand_op();  send();
        rand_op();  send();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check1("mid_rst_out_valid", out_valid_o, 1'b0);
        check1("mid_rst_in_ready", in_ready_o, 1'b1);
        check64("mid_rst_result", result_o, 64'd0);
        check64("mid_rst_store", store_data_o, 64'd0);
        out_ready_i = 1'b1;
        repeat (4) cycle();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_op();
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (4) cycle();
        check64("final_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
